// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target.
// Contents:
//   SPI_W        frame width in bits
//   CNT_W        width of the in-frame bit counter
//   spi_state_t  control FSM states
package spi_pkg;

  localparam int SPI_W = 8;
  localparam int CNT_W = $clog2(SPI_W);

  // WAIT_IDLE keeps us from joining a select that was already active
  // when reset released; IDLE waits for a select; SHIFT moves bits.
  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous pin.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high (all stages load RST_VAL)
//   d    in  asynchronous input pin
//   q    out synchronized copy of d, STAGES clocks of latency
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // New sample enters at bit 0 and walks toward the MSB, which is the
  // output stage.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Reset to the pin's idle level so no false edge is seen at startup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target (CPOL=0, CPHA=0), MSB first, SPI_W-bit frames.
// The SPI pins are oversampled in the clk domain. Core logic sees a byte-wide
// receive port (valid pulse) and a transmit holding register (valid/ready).
// Ports:
//   clk, rst               system clock, asynchronous active-high reset
//   cs_n, sclk, mosi       SPI pins from the master
//   miso, miso_oe          SPI data out and its enable (high while selected)
//   rx_data, rx_valid      last received byte, 1-clk pulse when it updates
//   tx_data, tx_valid,
//   tx_ready               holding register handshake (ready = empty)
//   tx_underrun            1-clk pulse: byte load found the register empty
//   frame_abort            1-clk pulse: deselect with a partial byte received
module spi_slave
  import spi_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [SPI_W-1:0] TX_IDLE     = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [SPI_W-1:0] rx_data,
  output logic             rx_valid,
  input  logic [SPI_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort
);

  logic cs_s, sclk_s, mosi_s;

  // All three pins use the same depth so their relative timing survives.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  spi_state_t       state_q, state_d;
  logic             cs_prev_q, cs_prev_d;
  logic             sclk_prev_q, sclk_prev_d;
  logic [7:0]       settle_q, settle_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [SPI_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_W-1:0] hold_q, hold_d;
  logic [SPI_W-1:0] rx_data_q, rx_data_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             frame_abort_q, frame_abort_d;

  logic             cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic             settle_done;
  logic             load_en;
  logic [SPI_W-1:0] load_byte;
  logic [SPI_W-1:0] rx_byte;

  assign cs_fall   =  cs_prev_q   & ~cs_s;
  assign cs_rise   = ~cs_prev_q   &  cs_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  // The synchronizers come out of reset showing "deselected" regardless of
  // the pin, so cs_s only reflects the real pin after SYNC_STAGES clocks.
  assign settle_done = (settle_q == 8'(SYNC_STAGES));

  // Next-state logic. A cs_n rise takes priority over any sclk edge seen in
  // the same clock. Byte loads (at select and at each byte boundary) share
  // one path so the holding register handshake is handled in one place.
  always_comb begin
    state_d       = state_q;
    cs_prev_d     = cs_s;
    sclk_prev_d   = sclk_s;
    settle_d      = settle_done ? settle_q : settle_q + 8'd1;
    bitcnt_d      = bitcnt_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    hold_d        = hold_q;
    rx_data_d     = rx_data_q;
    tx_ready_d    = tx_ready_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    load_en       = 1'b0;
    load_byte     = tx_ready_q ? TX_IDLE : hold_q;
    rx_byte       = {rx_sh_q[SPI_W-2:0], mosi_s};

    case (state_q)
      WAIT_IDLE: begin
        if (settle_done && cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          load_en   = 1'b1;
          bitcnt_d  = '0;
          miso_oe_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          if (bitcnt_q != '0) begin
            frame_abort_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_sh_d  = rx_byte;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(SPI_W - 1)) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bitcnt_q != '0) begin
            tx_sh_d = {tx_sh_q[SPI_W-2:0], 1'b0};
            miso_d  = tx_sh_q[SPI_W-2];
          end else begin
            load_en = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (load_en) begin
      tx_sh_d = load_byte;
      miso_d  = load_byte[SPI_W-1];
      if (tx_ready_q) begin
        tx_underrun_d = 1'b1;
      end else begin
        tx_ready_d = 1'b1;
      end
    end

    // A capture in the same clock as a load overrides the "now empty" flag.
    if (tx_valid && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  // All state and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_IDLE;
      cs_prev_q     <= 1'b1;
      sclk_prev_q   <= 1'b0;
      settle_q      <= '0;
      bitcnt_q      <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      hold_q        <= '0;
      rx_data_q     <= '0;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_prev_q     <= cs_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      settle_q      <= settle_d;
      bitcnt_q      <= bitcnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      hold_q        <= hold_d;
      rx_data_q     <= rx_data_d;
      tx_ready_q    <= tx_ready_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master (100 ns sclk
// period) against the DUT clocked at 100 MHz, with hand-computed expectations.
module tb_spi_slave;

  localparam time HALF = 50ns;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_abort;

  int vectors = 0;
  int miscompares = 0;

  int rx_count = 0;
  int underrun_count = 0;
  int abort_count = 0;
  int oe_cycles = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5ns clk = ~clk;

  // Pulse outputs are one clk wide, so sampling on the falling edge sees
  // each pulse exactly once.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) underrun_count++;
    if (frame_abort) abort_count++;
    if (miso_oe) oe_cycles++;
  end

  // Master helpers. The last byte of a select drops cs_n together with the
  // final sclk fall so no byte-boundary reload happens after the frame.
  task automatic spi_begin();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit last, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      sclk = 1'b1;
      rx[i] = miso;
      #HALF;
      sclk = 1'b0;
      if (i == 0 && last) cs_n = 1'b1;
    end
  endtask

  task automatic offer_tx(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!tx_ready) begin
      miscompares++;
      $display("[TB] FAIL offer_tx_timeout byte=%h: tx_ready=%b required 1", b, tx_ready);
    end
    @(posedge clk);
    #1ns tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort} !== 14'b0_0_00000000_0_1_0_0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got miso=%b oe=%b rx=%h rv=%b rdy=%b ur=%b ab=%b required 0 0 00 0 1 0 0",
               miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] r;
    int rx0;
    offer_tx(8'h3C);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL preload_ready: got %b required 0", tx_ready);
    end
    rx0 = rx_count;
    spi_begin();
    vectors++;
    if (miso_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL oe_selected: got %b required 1", miso_oe);
    end
    spi_byte(8'hA5, 1'b1, r);
    #(2*HALF);
    vectors++;
    if (r !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL single_miso: got %h required 3C", r);
    end
    vectors++;
    if (rx_count - rx0 !== 1 || rx_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL single_rx: got count=%0d data=%h required 1 A5", rx_count - rx0, rx_data);
    end
    vectors++;
    if (tx_ready !== 1'b1 || miso_oe !== 1'b0 || underrun_count !== 0) begin
      miscompares++;
      $display("[TB] FAIL single_after: got rdy=%b oe=%b ur=%0d required 1 0 0", tx_ready, miso_oe, underrun_count);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] r;
    int rx0, ur0;
    rx0 = rx_count;
    ur0 = underrun_count;
    spi_begin();
    spi_byte(8'h00, 1'b1, r);
    #(2*HALF);
    vectors++;
    if (r !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL underrun_miso: got %h required FF", r);
    end
    vectors++;
    if (underrun_count - ur0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL underrun_pulse: got %0d required 1", underrun_count - ur0);
    end
    vectors++;
    if (rx_count - rx0 !== 1 || rx_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL underrun_rx: got count=%0d data=%h required 1 00", rx_count - rx0, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1, r2;
    int base, ur0;
    offer_tx(8'h81);
    base = rx_log.size();
    ur0 = underrun_count;
    fork
      begin
        spi_begin();
        spi_byte(8'h11, 1'b0, r0);
        spi_byte(8'h22, 1'b0, r1);
        spi_byte(8'h33, 1'b1, r2);
        #(2*HALF);
      end
      begin
        offer_tx(8'h42);
        offer_tx(8'h24);
      end
    join
    vectors++;
    if ({r0, r1, r2} !== 24'h814224) begin
      miscompares++;
      $display("[TB] FAIL b2b_miso: got %h %h %h required 81 42 24", r0, r1, r2);
    end
    vectors++;
    if (rx_log.size() - base !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_rx_count: got %0d required 3", rx_log.size() - base);
    end else if ({rx_log[base], rx_log[base+1], rx_log[base+2]} !== 24'h112233) begin
      miscompares++;
      $display("[TB] FAIL b2b_rx_data: got %h %h %h required 11 22 33",
               rx_log[base], rx_log[base+1], rx_log[base+2]);
    end
    vectors++;
    if (underrun_count - ur0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_underrun: got %0d required 0", underrun_count - ur0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int rx0, ab0;
    offer_tx(8'h5A);
    rx0 = rx_count;
    ab0 = abort_count;
    spi_begin();
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #HALF;
    cs_n = 1'b1;
    #(4*HALF);
    vectors++;
    if (abort_count - ab0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL abort_pulse: got %0d required 1", abort_count - ab0);
    end
    vectors++;
    if (rx_count - rx0 !== 0 || rx_data !== 8'h33) begin
      miscompares++;
      $display("[TB] FAIL abort_rx: got count=%0d data=%h required 0 33", rx_count - rx0, rx_data);
    end
    offer_tx(8'h96);
    spi_begin();
    spi_byte(8'hC3, 1'b1, r);
    #(2*HALF);
    vectors++;
    if (r !== 8'h96 || rx_data !== 8'hC3 || rx_count - rx0 !== 1 || abort_count - ab0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL abort_next: got miso=%h rx=%h cnt=%0d ab=%0d required 96 C3 1 1",
               r, rx_data, rx_count - rx0, abort_count - ab0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    int rx0, oe0;
    spi_begin();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort} !== 14'b0_0_00000000_0_1_0_0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset_values: got miso=%b oe=%b rx=%h rv=%b rdy=%b ur=%b ab=%b required 0 0 00 0 1 0 0",
               miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx0 = rx_count;
    oe0 = oe_cycles;
    // Keep clocking a whole byte with the select still held low.
    spi_byte(8'hE7, 1'b0, r);
    #(2*HALF);
    vectors++;
    if (rx_count - rx0 !== 0 || oe_cycles - oe0 !== 0 || miso !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_ignored: got rx=%0d oe_cycles=%0d miso=%b required 0 0 0",
               rx_count - rx0, oe_cycles - oe0, miso);
    end
    cs_n = 1'b1;
    #(4*HALF);
    spi_begin();
    spi_byte(8'h7E, 1'b1, r);
    #(2*HALF);
    vectors++;
    if (r !== 8'hFF || rx_data !== 8'h7E || rx_count - rx0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL midframe_recover: got miso=%h rx=%h cnt=%0d required FF 7E 1", r, rx_data, rx_count - rx0);
    end
  endtask

  task automatic test_held_valid();
    logic [7:0] seq [5];
    logic [7:0] got [4];
    logic [7:0] r;
    int base, ur0;
    seq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    base = rx_log.size();
    ur0 = underrun_count;
    fork
      begin
        // tx_valid stays high throughout, including across shifter loads.
        for (int i = 0; i < 5; i++) begin
          int n;
          n = 0;
          @(negedge clk);
          tx_data  = seq[i];
          tx_valid = 1'b1;
          while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
          end
          vectors++;
          if (!tx_ready) begin
            miscompares++;
            $display("[TB] FAIL held_feed_timeout idx=%0d: tx_ready=%b required 1", i, tx_ready);
          end
          @(posedge clk);
        end
        #1ns tx_valid = 1'b0;
      end
      begin
        #300ns;
        for (int f = 0; f < 4; f++) begin
          spi_begin();
          spi_byte(8'(f + 1), 1'b1, r);
          got[f] = r;
          #(4*HALF);
        end
      end
    join
    vectors++;
    if ({got[0], got[1], got[2], got[3]} !== 32'hD1D2D3D4) begin
      miscompares++;
      $display("[TB] FAIL held_miso: got %h %h %h %h required D1 D2 D3 D4", got[0], got[1], got[2], got[3]);
    end
    vectors++;
    if (rx_log.size() - base !== 4) begin
      miscompares++;
      $display("[TB] FAIL held_rx_count: got %0d required 4", rx_log.size() - base);
    end else if ({rx_log[base], rx_log[base+1], rx_log[base+2], rx_log[base+3]} !== 32'h01020304) begin
      miscompares++;
      $display("[TB] FAIL held_rx_data: got %h %h %h %h required 01 02 03 04",
               rx_log[base], rx_log[base+1], rx_log[base+2], rx_log[base+3]);
    end
    vectors++;
    if (underrun_count - ur0 !== 0 || tx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_after: got ur=%0d rdy=%b required 0 0", underrun_count - ur0, tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_held_valid();
    #100ns;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
